// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM.
// Optional mult/div support is enabled by defining MIPS_CTRL_MULDIV_EN.
package mips_ctrl_pkg;

    localparam int unsigned ISA_OPCODE_W = 6;
    localparam int unsigned ISA_FUNCT_W  = 6;

    localparam logic [ISA_OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [ISA_OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [ISA_OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [ISA_OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [ISA_OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [ISA_OPCODE_W-1:0] OP_J     = 6'b000010;

    localparam logic [ISA_FUNCT_W-1:0] FN_MULT = 6'b011000;
    localparam logic [ISA_FUNCT_W-1:0] FN_DIV  = 6'b011010;
    localparam logic [ISA_FUNCT_W-1:0] FN_MFHI = 6'b010000;
    localparam logic [ISA_FUNCT_W-1:0] FN_MFLO = 6'b010010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_ADDI  = 2'b10;
    localparam logic [1:0] ALUOP_FUNCT = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH       = 4'd0,
        S_DECODE      = 4'd1,
        S_MEM_ADDR    = 4'd2,
        S_MEM_RD      = 4'd3,
        S_MEM_WB      = 4'd4,
        S_MEM_WR      = 4'd5,
        S_R_EXEC      = 4'd6,
        S_R_WB        = 4'd7,
        S_BRANCH      = 4'd8,
        S_ADDI_EXEC   = 4'd9,
        S_ADDI_WB     = 4'd10,
        S_JUMP        = 4'd11,
        S_MULDIV_WAIT = 4'd12
    } state_e;

    // Datapath control word produced by the state decoder.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       hilo_write;
        logic       busy;
    } ctrl_t;

    function automatic logic opcode_legal(input logic [ISA_OPCODE_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

    function automatic logic is_muldiv(input logic [ISA_FUNCT_W-1:0] fn);
        return (fn == FN_MULT) || (fn == FN_DIV);
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// State -> datapath control decoder. Only the FETCH strobes look at mem_ready.
// MIPS_CTRL_MULDIV_EN adds the MULDIV_WAIT state and its hilo_write strobe.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
`ifdef MIPS_CTRL_MULDIV_EN
    input  logic   cnt_zero_i,
`endif
    output ctrl_t  ctrl_o
);

    // Moore decode; unlisted encodings leave every control low.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.busy      = 1'b1;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.busy      = 1'b1;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
                ctrl_o.busy     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.busy       = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
                ctrl_o.busy      = 1'b1;
            end
            S_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_RT;
                ctrl_o.alu_op    = ALUOP_FUNCT;
                ctrl_o.busy      = 1'b1;
            end
            S_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.busy      = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_RT;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.busy          = 1'b1;
            end
            S_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADDI;
                ctrl_o.busy      = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.busy      = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
                ctrl_o.busy      = 1'b1;
            end
`ifdef MIPS_CTRL_MULDIV_EN
            S_MULDIV_WAIT: begin
                ctrl_o.hilo_write = cnt_zero_i;
                ctrl_o.busy       = 1'b1;
            end
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control: per-instruction state sequence with memory handshake.
// Define MIPS_CTRL_MULDIV_EN to add mult/div occupancy tracking and hilo_write;
// without it mult/div funct codes are reported through illegal_op.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W   = 6,
    parameter int unsigned FUNCT_W    = 6,
    parameter int unsigned ALUOP_W    = 2
`ifdef MIPS_CTRL_MULDIV_EN
    ,
    parameter int unsigned MULDIV_LAT = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  alu_op,
    output logic [1:0]          pc_source,
    output logic                hilo_write,
    output logic                illegal_op,
    output logic                busy
);

    logic [ISA_OPCODE_W-1:0] op;
    logic [ISA_FUNCT_W-1:0]  fn;
    state_e                  state_q;
    ctrl_t                   ctrl_c;
    ctrl_t                   ctrl_g;
    logic                    illegal_c;

    assign op = ISA_OPCODE_W'(opcode);
    assign fn = ISA_FUNCT_W'(funct);

`ifdef MIPS_CTRL_MULDIV_EN
    localparam int unsigned CNT_W = $clog2(MULDIV_LAT);
    logic [CNT_W-1:0] cnt_q;
    logic             cnt_zero_c;
    assign cnt_zero_c = (cnt_q == '0);
`endif

    // State sequencing (and mult/div occupancy counter when enabled).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
`ifdef MIPS_CTRL_MULDIV_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_FETCH:     if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_RTYPE:     state_q <= S_R_EXEC;
                        OP_LW, OP_SW: state_q <= S_MEM_ADDR;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_ADDI:      state_q <= S_ADDI_EXEC;
                        OP_J:         state_q <= S_JUMP;
                        default:      state_q <= S_FETCH;
                    endcase
                end
                S_MEM_ADDR:  state_q <= (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:    if (mem_ready) state_q <= S_MEM_WB;
                S_MEM_WB:    state_q <= S_FETCH;
                S_MEM_WR:    if (mem_ready) state_q <= S_FETCH;
`ifdef MIPS_CTRL_MULDIV_EN
                S_R_EXEC: begin
                    if (is_muldiv(fn)) begin
                        state_q <= S_MULDIV_WAIT;
                        cnt_q   <= CNT_W'(MULDIV_LAT - 1);
                    end else begin
                        state_q <= S_R_WB;
                    end
                end
                S_MULDIV_WAIT: begin
                    if (cnt_zero_c) state_q <= S_FETCH;
                    else            cnt_q   <= cnt_q - CNT_W'(1);
                end
`else
                S_R_EXEC:    state_q <= is_muldiv(fn) ? S_FETCH : S_R_WB;
`endif
                S_R_WB:      state_q <= S_FETCH;
                S_BRANCH:    state_q <= S_FETCH;
                S_ADDI_EXEC: state_q <= S_ADDI_WB;
                S_ADDI_WB:   state_q <= S_FETCH;
                S_JUMP:      state_q <= S_FETCH;
                default:     state_q <= S_FETCH;
            endcase
        end
    end

    mips_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
`ifdef MIPS_CTRL_MULDIV_EN
        .cnt_zero_i  (cnt_zero_c),
`endif
        .ctrl_o      (ctrl_c)
    );

    // Unsupported opcode in DECODE, or mult/div funct with no mult/div unit.
`ifdef MIPS_CTRL_MULDIV_EN
    assign illegal_c = (state_q == S_DECODE) && !opcode_legal(op);
`else
    assign illegal_c = ((state_q == S_DECODE) && !opcode_legal(op)) ||
                       ((state_q == S_R_EXEC) && is_muldiv(fn));
`endif

    // Everything is held low while reset is asserted.
    assign ctrl_g        = rst ? '0 : ctrl_c;
    assign illegal_op    = illegal_c & ~rst;
    assign pc_write      = ctrl_g.pc_write;
    assign pc_write_cond = ctrl_g.pc_write_cond;
    assign i_or_d        = ctrl_g.i_or_d;
    assign mem_read      = ctrl_g.mem_read;
    assign mem_write     = ctrl_g.mem_write;
    assign ir_write      = ctrl_g.ir_write;
    assign mem_to_reg    = ctrl_g.mem_to_reg;
    assign reg_dst       = ctrl_g.reg_dst;
    assign reg_write     = ctrl_g.reg_write;
    assign alu_src_a     = ctrl_g.alu_src_a;
    assign alu_src_b     = ctrl_g.alu_src_b;
    assign alu_op        = ALUOP_W'(ctrl_g.alu_op);
    assign pc_source     = ctrl_g.pc_source;
    assign hilo_write    = ctrl_g.hilo_write;
    assign busy          = ctrl_g.busy;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control; expected control words are queued
// as each cycle is driven and popped when the outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_mips_multicycle_control;

`ifdef MIPS_CTRL_MULDIV_EN
    localparam int unsigned LAT = 4;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       hilo_write;
        logic       illegal_op;
        logic       busy;
    } obs_t;

    typedef enum int {
        K_RST, K_FETCH, K_DEC, K_DEC_ILL, K_MADDR, K_MRD, K_MWB, K_MWR,
        K_REX, K_REX_ILL, K_RWB, K_BR, K_AEX, K_AWB, K_J, K_MDW, K_MDW_LAST
    } kind_e;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_ready = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, hilo_write, illegal_op, busy;
    logic [1:0] alu_src_b, alu_op, pc_source;

    obs_t       obs;
    obs_t       exp_q[$];
    string      tag_q[$];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    mips_multicycle_control #(
        .OPCODE_W   (6),
        .FUNCT_W    (6),
`ifdef MIPS_CTRL_MULDIV_EN
        .ALUOP_W    (2),
        .MULDIV_LAT (LAT)
`else
        .ALUOP_W    (2)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .funct         (funct),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .hilo_write    (hilo_write),
        .illegal_op    (illegal_op),
        .busy          (busy)
    );

    assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, hilo_write, illegal_op, busy};

    // Reference control word for each kind of cycle.
    function automatic obs_t exp_of(input kind_e k, input logic rdy);
        obs_t e;
        e = '0;
        case (k)
            K_FETCH: begin
                e.mem_read = 1'b1; e.alu_src_b = 2'b01;
                e.ir_write = rdy;  e.pc_write  = rdy;
            end
            K_DEC:      begin e.alu_src_b = 2'b11; e.busy = 1'b1; end
            K_DEC_ILL:  begin e.alu_src_b = 2'b11; e.busy = 1'b1; e.illegal_op = 1'b1; end
            K_MADDR:    begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.busy = 1'b1; end
            K_MRD:      begin e.mem_read = 1'b1; e.i_or_d = 1'b1; e.busy = 1'b1; end
            K_MWB:      begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.busy = 1'b1; end
            K_MWR:      begin e.mem_write = 1'b1; e.i_or_d = 1'b1; e.busy = 1'b1; end
            K_REX:      begin e.alu_src_a = 1'b1; e.alu_op = 2'b11; e.busy = 1'b1; end
            K_REX_ILL:  begin e.alu_src_a = 1'b1; e.alu_op = 2'b11; e.busy = 1'b1; e.illegal_op = 1'b1; end
            K_RWB:      begin e.reg_write = 1'b1; e.reg_dst = 1'b1; e.busy = 1'b1; end
            K_BR: begin
                e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_write_cond = 1'b1;
                e.pc_source = 2'b01; e.busy = 1'b1;
            end
            K_AEX:      begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b10; e.busy = 1'b1; end
            K_AWB:      begin e.reg_write = 1'b1; e.busy = 1'b1; end
            K_J:        begin e.pc_write = 1'b1; e.pc_source = 2'b10; e.busy = 1'b1; end
            K_MDW:      begin e.busy = 1'b1; end
            K_MDW_LAST: begin e.busy = 1'b1; e.hilo_write = 1'b1; end
            default:    e = '0;
        endcase
        return e;
    endfunction

    task automatic check_head();
        obs_t  e;
        string t;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%b", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%b expected=%b", t, obs, e);
            end
        end
    endtask

    // Drive one clock cycle, queue its expectation, check on the falling edge.
    task automatic cyc(input logic rdy, input kind_e k, input string tag);
        rst       = (k == K_RST);
        mem_ready = rdy;
        exp_q.push_back(exp_of(k, rdy));
        tag_q.push_back(tag);
        @(negedge clk);
        check_head();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "simulation time limit");
    end

    initial begin
        @(posedge clk);
        #1;
        cyc(1'b1, K_RST, "reset_a");
        cyc(1'b0, K_RST, "reset_b");

        // R-type add
        opcode = 6'b000000; funct = 6'b100000;
        cyc(1'b1, K_FETCH, "r_fetch");
        cyc(1'b1, K_DEC,   "r_decode");
        cyc(1'b1, K_REX,   "r_exec");
        cyc(1'b1, K_RWB,   "r_wb");

        // addi with fetch stalled two cycles
        opcode = 6'b001000;
        cyc(1'b0, K_FETCH, "addi_fetch_stall1");
        cyc(1'b0, K_FETCH, "addi_fetch_stall2");
        cyc(1'b1, K_FETCH, "addi_fetch");
        cyc(1'b0, K_DEC,   "addi_decode");
        cyc(1'b1, K_AEX,   "addi_exec");
        cyc(1'b1, K_AWB,   "addi_wb");

        // lw with three wait cycles in MEM_RD
        opcode = 6'b100011;
        cyc(1'b1, K_FETCH, "lw_fetch");
        cyc(1'b0, K_DEC,   "lw_decode");
        cyc(1'b1, K_MADDR, "lw_addr");
        cyc(1'b0, K_MRD,   "lw_rd_wait1");
        cyc(1'b0, K_MRD,   "lw_rd_wait2");
        cyc(1'b0, K_MRD,   "lw_rd_wait3");
        cyc(1'b1, K_MRD,   "lw_rd_done");
        cyc(1'b0, K_MWB,   "lw_wb");

        // sw with one wait cycle
        opcode = 6'b101011;
        cyc(1'b1, K_FETCH, "sw_fetch");
        cyc(1'b1, K_DEC,   "sw_decode");
        cyc(1'b1, K_MADDR, "sw_addr");
        cyc(1'b0, K_MWR,   "sw_wr_wait");
        cyc(1'b1, K_MWR,   "sw_wr_done");

        // beq then j
        opcode = 6'b000100;
        cyc(1'b1, K_FETCH, "beq_fetch");
        cyc(1'b1, K_DEC,   "beq_decode");
        cyc(1'b1, K_BR,    "beq_branch");
        opcode = 6'b000010;
        cyc(1'b1, K_FETCH, "j_fetch");
        cyc(1'b1, K_DEC,   "j_decode");
        cyc(1'b1, K_J,     "j_jump");

        // illegal opcode then mfhi on the normal R path
        opcode = 6'b111111;
        cyc(1'b1, K_FETCH,   "ill_fetch");
        cyc(1'b1, K_DEC_ILL, "ill_decode");
        opcode = 6'b000000; funct = 6'b010000;
        cyc(1'b1, K_FETCH, "mfhi_fetch");
        cyc(1'b1, K_DEC,   "mfhi_decode");
        cyc(1'b1, K_REX,   "mfhi_exec");
        cyc(1'b1, K_RWB,   "mfhi_wb");

        // mult
        funct = 6'b011000;
        cyc(1'b1, K_FETCH, "mult_fetch");
        cyc(1'b1, K_DEC,   "mult_decode");
`ifdef MIPS_CTRL_MULDIV_EN
        cyc(1'b1, K_REX,   "mult_exec");
        for (int i = 0; i < int'(LAT) - 1; i++) cyc(1'b1, K_MDW, "mult_wait");
        cyc(1'b1, K_MDW_LAST, "mult_wait_last");
`else
        cyc(1'b1, K_REX_ILL, "mult_exec_illegal");
`endif

        // lw interrupted by reset while waiting in MEM_RD
        opcode = 6'b100011; funct = 6'b000000;
        cyc(1'b1, K_FETCH, "lwrst_fetch");
        cyc(1'b1, K_DEC,   "lwrst_decode");
        cyc(1'b1, K_MADDR, "lwrst_addr");
        cyc(1'b0, K_MRD,   "lwrst_rd_wait");
        cyc(1'b1, K_RST,   "lwrst_in_reset");
        cyc(1'b1, K_FETCH, "lwrst_refetch");
        cyc(1'b1, K_DEC,   "lwrst_redecode");
        cyc(1'b1, K_MADDR, "lwrst_readdr");
        cyc(1'b1, K_MRD,   "lwrst_rd");
        cyc(1'b1, K_MWB,   "lwrst_wb");
        cyc(1'b0, K_FETCH, "final_fetch_idle");

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
